// File: rtl/proj_sketch_ctrl.sv
// rtl/proj_sketch_ctrl.sv - round-robin job controller feeding a min-signature sorter
//
// Grants one requester at a time, clears the external sorter, streams the
// granted requester's elements into it with sequential indices, lets it
// settle, then captures the sorter's retained indices as the job result.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   job_req/job_len   per-requester request level and element count
//   job_gnt           one-hot grant, held until the result handshake
//   s_valid/s_ready   per-requester element handshake
//   s_signature       per-requester element signature
//   srt_*             registered sorter feed (clear, signature, index)
//   srt_smallest_idx  sorter's retained indices
//   res_*             result handshake, owner and captured indices
//   busy              high whenever not idle
module proj_sketch_ctrl #(
    parameter int INDICES_COUNT = 4,
    parameter int INDICE_LEN    = 8,
    parameter int SIGNATURE_LEN = 32,
    parameter int NUM_REQ       = 2,
    parameter int DRAIN_CYCLES  = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  job_req,
    input  logic [NUM_REQ*INDICE_LEN-1:0]       job_len,
    output logic [NUM_REQ-1:0]                  job_gnt,
    input  logic [NUM_REQ-1:0]                  s_valid,
    input  logic [NUM_REQ*SIGNATURE_LEN-1:0]    s_signature,
    output logic [NUM_REQ-1:0]                  s_ready,
    output logic                                srt_clear,
    output logic [SIGNATURE_LEN-1:0]            srt_signature,
    output logic [INDICE_LEN-1:0]               srt_index,
    input  logic [INDICES_COUNT*INDICE_LEN-1:0] srt_smallest_idx,
    output logic                                res_valid,
    output logic [NUM_REQ-1:0]                  res_owner,
    output logic [INDICES_COUNT*INDICE_LEN-1:0] res_idx,
    input  logic                                res_ready,
    output logic                                busy
);

    localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_RESULT
    } state_t;

    state_t                              state_q, state_d;
    logic [NUM_REQ-1:0]                  gnt_q, gnt_d;
    logic [RW-1:0]                       gidx_q, gidx_d;
    logic [RW-1:0]                       last_q, last_d;
    logic [INDICE_LEN-1:0]               len_q, len_d;
    logic [INDICE_LEN-1:0]               cnt_q, cnt_d;
    logic [DW-1:0]                       dcnt_q, dcnt_d;
    logic [NUM_REQ-1:0]                  s_ready_q, s_ready_d;
    logic                                srt_clear_q, srt_clear_d;
    logic [SIGNATURE_LEN-1:0]            srt_sig_q, srt_sig_d;
    logic [INDICE_LEN-1:0]               srt_idx_q, srt_idx_d;
    logic                                res_valid_q, res_valid_d;
    logic [NUM_REQ-1:0]                  res_owner_q, res_owner_d;
    logic [INDICES_COUNT*INDICE_LEN-1:0] res_idx_q, res_idx_d;
    logic                                busy_q, busy_d;

    logic                                arb_found;
    logic [RW-1:0]                       arb_idx;
    logic [RW-1:0]                       arb_cand;
    logic                                accept;
    logic [SIGNATURE_LEN-1:0]            sig_sel;

    // Round-robin search starting one past the last-served requester.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            arb_cand = RW'((int'(last_q) + i) % NUM_REQ);
            if (!arb_found && job_req[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    assign accept  = s_valid[gidx_q] & s_ready_q[gidx_q];
    assign sig_sel = s_signature[gidx_q*SIGNATURE_LEN +: SIGNATURE_LEN];

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gidx_d      = gidx_q;
        last_d      = last_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        dcnt_d      = dcnt_q;
        s_ready_d   = s_ready_q;
        res_valid_d = res_valid_q;
        res_owner_d = res_owner_q;
        res_idx_d   = res_idx_q;
        busy_d      = busy_q;
        // The sorter ignores all-ones, so this is the idle feed value.
        srt_clear_d = 1'b0;
        srt_sig_d   = '1;
        srt_idx_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    gnt_d       = NUM_REQ'(1) << arb_idx;
                    gidx_d      = arb_idx;
                    len_d       = job_len[arb_idx*INDICE_LEN +: INDICE_LEN];
                    srt_clear_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_d  = '0;
                dcnt_d = '0;
                if (len_q == '0) begin
                    state_d = ST_DRAIN;
                end else begin
                    s_ready_d = gnt_q;
                    state_d   = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    srt_sig_d = sig_sel;
                    srt_idx_d = cnt_q;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == len_q - 1'b1) begin
                        s_ready_d = '0;
                        state_d   = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Gives the sorter time to absorb the last inserted element.
                if (dcnt_q == DW'(DRAIN_CYCLES - 1)) begin
                    res_idx_d   = srt_smallest_idx;
                    res_valid_d = 1'b1;
                    res_owner_d = gnt_q;
                    state_d     = ST_RESULT;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    res_owner_d = '0;
                    gnt_d       = '0;
                    last_d      = gidx_q;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gidx_q      <= '0;
            // Pointing at the last requester makes requester 0 first in line.
            last_q      <= RW'(NUM_REQ - 1);
            len_q       <= '0;
            cnt_q       <= '0;
            dcnt_q      <= '0;
            s_ready_q   <= '0;
            srt_clear_q <= 1'b0;
            srt_sig_q   <= '1;
            srt_idx_q   <= '0;
            res_valid_q <= 1'b0;
            res_owner_q <= '0;
            res_idx_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gidx_q      <= gidx_d;
            last_q      <= last_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            dcnt_q      <= dcnt_d;
            s_ready_q   <= s_ready_d;
            srt_clear_q <= srt_clear_d;
            srt_sig_q   <= srt_sig_d;
            srt_idx_q   <= srt_idx_d;
            res_valid_q <= res_valid_d;
            res_owner_q <= res_owner_d;
            res_idx_q   <= res_idx_d;
            busy_q      <= busy_d;
        end
    end

    assign job_gnt       = gnt_q;
    assign s_ready       = s_ready_q;
    assign srt_clear     = srt_clear_q;
    assign srt_signature = srt_sig_q;
    assign srt_index     = srt_idx_q;
    assign res_valid     = res_valid_q;
    assign res_owner     = res_owner_q;
    assign res_idx       = res_idx_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_proj_sketch_ctrl.sv
// tb/tb_proj_sketch_ctrl.sv - directed self-checking bench for proj_sketch_ctrl
module tb_proj_sketch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  job_req;
    logic [15:0] job_len;
    logic [1:0]  job_gnt;
    logic [1:0]  s_valid;
    logic [63:0] s_signature;
    logic [1:0]  s_ready;
    logic        srt_clear;
    logic [31:0] srt_signature;
    logic [7:0]  srt_index;
    logic [31:0] srt_smallest_idx;
    logic        res_valid;
    logic [1:0]  res_owner;
    logic [31:0] res_idx;
    logic        res_ready;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    int n;

    logic [31:0] m_sig [4];
    logic [7:0]  m_idx [4];
    logic        override;
    int          ins_pos;

    always @(posedge clk) begin
        if (rst || srt_clear) begin
            for (int k = 0; k < 4; k++) begin
                m_sig[k] <= '1;
                m_idx[k] <= '0;
            end
        end else if (srt_signature != 32'hFFFF_FFFF) begin
            ins_pos = 4;
            for (int k = 3; k >= 0; k--)
                if (srt_signature < m_sig[k]) ins_pos = k;
            for (int k = 0; k < 4; k++) begin
                if (k == ins_pos) begin
                    m_sig[k] <= srt_signature;
                    m_idx[k] <= srt_index;
                end else if (k > ins_pos) begin
                    m_sig[k] <= m_sig[k-1];
                    m_idx[k] <= m_idx[k-1];
                end
            end
        end
    end

    assign srt_smallest_idx = override ? 32'hDEAD_BEEF : {m_idx[3], m_idx[2], m_idx[1], m_idx[0]};

    proj_sketch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .job_req         (job_req),
        .job_len         (job_len),
        .job_gnt         (job_gnt),
        .s_valid         (s_valid),
        .s_signature     (s_signature),
        .s_ready         (s_ready),
        .srt_clear       (srt_clear),
        .srt_signature   (srt_signature),
        .srt_index       (srt_index),
        .srt_smallest_idx(srt_smallest_idx),
        .res_valid       (res_valid),
        .res_owner       (res_owner),
        .res_idx         (res_idx),
        .res_ready       (res_ready),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        n_chk++; if (job_gnt !== 2'b00) begin n_fail++; $error("FAIL %s.gnt: observed %0h expected 0", tag, job_gnt); end
        n_chk++; if (s_ready !== 2'b00) begin n_fail++; $error("FAIL %s.s_ready: observed %0h expected 0", tag, s_ready); end
        n_chk++; if (res_valid !== 1'b0) begin n_fail++; $error("FAIL %s.res_valid: observed %0h expected 0", tag, res_valid); end
        n_chk++; if (res_owner !== 2'b00) begin n_fail++; $error("FAIL %s.res_owner: observed %0h expected 0", tag, res_owner); end
        n_chk++; if (res_idx !== 32'h0) begin n_fail++; $error("FAIL %s.res_idx: observed %0h expected 0", tag, res_idx); end
        n_chk++; if (srt_index !== 8'h0) begin n_fail++; $error("FAIL %s.srt_index: observed %0h expected 0", tag, srt_index); end
        n_chk++; if (srt_signature !== 32'hFFFF_FFFF) begin n_fail++; $error("FAIL %s.srt_sig: observed %0h expected ffffffff", tag, srt_signature); end
        n_chk++; if (srt_clear !== 1'b0) begin n_fail++; $error("FAIL %s.srt_clear: observed %0h expected 0", tag, srt_clear); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $error("FAIL %s.busy: observed %0h expected 0", tag, busy); end
    endtask

    task automatic run_to_result(input int max, output int cnt);
        cnt = 0;
        while (res_valid !== 1'b1 && cnt < max) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; job_req = '0; job_len = '0; s_valid = '0;
        s_signature = '0; res_ready = 1'b0; override = 1'b0;
        tick(); tick();
        chk_reset("rst0");
        rst = 1'b0;

        s_valid = 2'b10; s_signature[63:32] = 32'd5;
        job_len = {8'd0, 8'd3}; job_req = 2'b01;
        tick();
        n_chk++; if (job_gnt !== 2'b01) begin n_fail++; $error("FAIL a.gnt: observed %0h expected 1", job_gnt); end
        n_chk++; if (srt_clear !== 1'b1) begin n_fail++; $error("FAIL a.clear: observed %0h expected 1", srt_clear); end
        n_chk++; if (busy !== 1'b1) begin n_fail++; $error("FAIL a.busy: observed %0h expected 1", busy); end
        n_chk++; if (s_ready !== 2'b00) begin n_fail++; $error("FAIL a.rdy_clear: observed %0h expected 0", s_ready); end
        job_req = 2'b00; s_valid = 2'b11; s_signature[31:0] = 32'd30;
        tick();
        n_chk++; if (srt_clear !== 1'b0) begin n_fail++; $error("FAIL a.clear_end: observed %0h expected 0", srt_clear); end
        n_chk++; if (s_ready !== 2'b01) begin n_fail++; $error("FAIL a.rdy: observed %0h expected 1", s_ready); end
        n_chk++; if (srt_signature !== 32'hFFFF_FFFF) begin n_fail++; $error("FAIL a.sig_idle: observed %0h expected ffffffff", srt_signature); end
        tick();
        n_chk++; if (srt_signature !== 32'd30) begin n_fail++; $error("FAIL a.sig0: observed %0h expected 1e", srt_signature); end
        n_chk++; if (srt_index !== 8'd0) begin n_fail++; $error("FAIL a.idx0: observed %0h expected 0", srt_index); end
        s_signature[31:0] = 32'd10;
        tick();
        n_chk++; if (srt_signature !== 32'd10) begin n_fail++; $error("FAIL a.sig1: observed %0h expected a", srt_signature); end
        n_chk++; if (srt_index !== 8'd1) begin n_fail++; $error("FAIL a.idx1: observed %0h expected 1", srt_index); end
        s_signature[31:0] = 32'd20;
        tick();
        n_chk++; if (srt_signature !== 32'd20) begin n_fail++; $error("FAIL a.sig2: observed %0h expected 14", srt_signature); end
        n_chk++; if (srt_index !== 8'd2) begin n_fail++; $error("FAIL a.idx2: observed %0h expected 2", srt_index); end
        n_chk++; if (s_ready !== 2'b00) begin n_fail++; $error("FAIL a.rdy_off: observed %0h expected 0", s_ready); end
        s_valid = 2'b00;
        tick();
        n_chk++; if (srt_signature !== 32'hFFFF_FFFF) begin n_fail++; $error("FAIL a.drain_sig: observed %0h expected ffffffff", srt_signature); end
        n_chk++; if (res_valid !== 1'b0) begin n_fail++; $error("FAIL a.drain_rv: observed %0h expected 0", res_valid); end
        tick();
        n_chk++; if (res_valid !== 1'b1) begin n_fail++; $error("FAIL a.rv: observed %0h expected 1", res_valid); end
        n_chk++; if (res_owner !== 2'b01) begin n_fail++; $error("FAIL a.owner: observed %0h expected 1", res_owner); end
        n_chk++; if (res_idx !== 32'h0000_0201) begin n_fail++; $error("FAIL a.res_idx: observed %0h expected 201", res_idx); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_chk++; if (res_valid !== 1'b0) begin n_fail++; $error("FAIL a.rv_done: observed %0h expected 0", res_valid); end
        n_chk++; if (job_gnt !== 2'b00) begin n_fail++; $error("FAIL a.gnt_done: observed %0h expected 0", job_gnt); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $error("FAIL a.busy_done: observed %0h expected 0", busy); end

        rst = 1'b1; tick(); rst = 1'b0;
        job_len = 16'h0; job_req = 2'b11;
        tick();
        n_chk++; if (job_gnt !== 2'b01) begin n_fail++; $error("FAIL b.gnt0: observed %0h expected 1", job_gnt); end
        n_chk++; if (srt_clear !== 1'b1) begin n_fail++; $error("FAIL b.clear: observed %0h expected 1", srt_clear); end
        tick();
        n_chk++; if (s_ready !== 2'b00) begin n_fail++; $error("FAIL b.rdy_none: observed %0h expected 0", s_ready); end
        n_chk++; if (busy !== 1'b1) begin n_fail++; $error("FAIL b.busy: observed %0h expected 1", busy); end
        tick();
        n_chk++; if (res_valid !== 1'b0) begin n_fail++; $error("FAIL b.rv_early: observed %0h expected 0", res_valid); end
        tick();
        n_chk++; if (res_valid !== 1'b1) begin n_fail++; $error("FAIL b.rv: observed %0h expected 1", res_valid); end
        n_chk++; if (res_owner !== 2'b01) begin n_fail++; $error("FAIL b.owner: observed %0h expected 1", res_owner); end
        n_chk++; if (res_idx !== 32'h0) begin n_fail++; $error("FAIL b.res_idx: observed %0h expected 0", res_idx); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $error("FAIL b.idle: observed %0h expected 0", busy); end
        tick();
        n_chk++; if (job_gnt !== 2'b10) begin n_fail++; $error("FAIL b.gnt1: observed %0h expected 2", job_gnt); end
        job_req = 2'b01;
        run_to_result(10, n);
        n_chk++; if (n !== 3) begin n_fail++; $error("FAIL b.len0_lat: observed %0d expected 3", n); end
        n_chk++; if (res_owner !== 2'b10) begin n_fail++; $error("FAIL b.owner1: observed %0h expected 2", res_owner); end
        job_len = {8'd0, 8'd3};
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_chk++; if (job_gnt !== 2'b00) begin n_fail++; $error("FAIL b.gnt_rel: observed %0h expected 0", job_gnt); end
        tick();
        n_chk++; if (job_gnt !== 2'b01) begin n_fail++; $error("FAIL b.gnt2: observed %0h expected 1", job_gnt); end

        job_req = 2'b00; s_valid = 2'b01; s_signature[31:0] = 32'd7;
        tick();
        n_chk++; if (s_ready !== 2'b01) begin n_fail++; $error("FAIL c.rdy: observed %0h expected 1", s_ready); end
        tick();
        n_chk++; if (srt_signature !== 32'd7) begin n_fail++; $error("FAIL c.sig0: observed %0h expected 7", srt_signature); end
        n_chk++; if (srt_index !== 8'd0) begin n_fail++; $error("FAIL c.idx0: observed %0h expected 0", srt_index); end
        s_valid = 2'b00;
        tick();
        n_chk++; if (srt_signature !== 32'hFFFF_FFFF) begin n_fail++; $error("FAIL c.gap_sig: observed %0h expected ffffffff", srt_signature); end
        n_chk++; if (srt_index !== 8'd0) begin n_fail++; $error("FAIL c.gap_idx: observed %0h expected 0", srt_index); end
        s_valid = 2'b01; s_signature[31:0] = 32'd3;
        tick();
        n_chk++; if (srt_signature !== 32'd3) begin n_fail++; $error("FAIL c.sig1: observed %0h expected 3", srt_signature); end
        n_chk++; if (srt_index !== 8'd1) begin n_fail++; $error("FAIL c.idx1: observed %0h expected 1", srt_index); end
        s_valid = 2'b00;
        tick();
        n_chk++; if (srt_signature !== 32'hFFFF_FFFF) begin n_fail++; $error("FAIL c.gap2_sig: observed %0h expected ffffffff", srt_signature); end
        s_valid = 2'b01; s_signature[31:0] = 32'd5;
        tick();
        n_chk++; if (srt_signature !== 32'd5) begin n_fail++; $error("FAIL c.sig2: observed %0h expected 5", srt_signature); end
        n_chk++; if (srt_index !== 8'd2) begin n_fail++; $error("FAIL c.idx2: observed %0h expected 2", srt_index); end
        n_chk++; if (s_ready !== 2'b00) begin n_fail++; $error("FAIL c.rdy_off: observed %0h expected 0", s_ready); end
        s_valid = 2'b00;
        tick(); tick();
        n_chk++; if (res_valid !== 1'b1) begin n_fail++; $error("FAIL c.rv: observed %0h expected 1", res_valid); end
        n_chk++; if (res_idx !== 32'h0000_0201) begin n_fail++; $error("FAIL c.res_idx: observed %0h expected 201", res_idx); end
        override = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++; if (res_valid !== 1'b1) begin n_fail++; $error("FAIL c.hold_rv: observed %0h expected 1", res_valid); end
            n_chk++; if (res_idx !== 32'h0000_0201) begin n_fail++; $error("FAIL c.hold_idx: observed %0h expected 201", res_idx); end
            n_chk++; if (res_owner !== 2'b01) begin n_fail++; $error("FAIL c.hold_owner: observed %0h expected 1", res_owner); end
        end
        override = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_chk++; if (res_valid !== 1'b0) begin n_fail++; $error("FAIL c.rv_done: observed %0h expected 0", res_valid); end

        job_len = {8'd0, 8'd4}; job_req = 2'b01;
        tick();
        n_chk++; if (job_gnt !== 2'b01) begin n_fail++; $error("FAIL d.gnt: observed %0h expected 1", job_gnt); end
        job_req = 2'b00; s_valid = 2'b01; s_signature[31:0] = 32'd9;
        tick();
        tick();
        s_signature[31:0] = 32'd8;
        tick();
        n_chk++; if (srt_index !== 8'd1) begin n_fail++; $error("FAIL d.idx1: observed %0h expected 1", srt_index); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("d.rst");
        s_valid = 2'b00;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_chk++; if (res_valid !== 1'b0) begin n_fail++; $error("FAIL d.no_result: observed %0h expected 0", res_valid); end
            n_chk++; if (busy !== 1'b0) begin n_fail++; $error("FAIL d.stay_idle: observed %0h expected 0", busy); end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
